// File: rtl/object_centroid.sv
// object_centroid: per-frame foreground count, bounding box and centroid.
// Totals are snapshotted at each frame boundary and divided bit-serially.
module object_centroid #(
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Cam_enable_in,
  input  logic [9:0]  CamHsync_count_in,
  input  logic [10:0] CamPix_count_in,
  input  logic [15:0] data_in,
  output logic        result_valid,
  output logic        found,
  output logic [10:0] centroid_x,
  output logic [9:0]  centroid_y,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic [21:0] pix_count,
  output logic        overrun
);

  localparam logic [21:0] MIN_P = 22'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_q, state_d;

  logic qual, bnd, unused_data;
  assign qual = Cam_enable_in & data_in[15];
  assign bnd  = Cam_enable_in
             && (CamHsync_count_in == 10'd0)
             && (CamPix_count_in == 11'd0);
  assign unused_data = ^data_in[14:0];

  logic [21:0] cnt_q, cnt_d;
  logic [31:0] sx_q, sx_d, sy_q, sy_d;
  logic [10:0] xmn_q, xmn_d, xmx_q, xmx_d;
  logic [9:0]  ymn_q, ymn_d, ymx_q, ymx_d;

  logic [21:0] s_cnt_q;
  logic [10:0] s_xmn_q, s_xmx_q;
  logic [9:0]  s_ymn_q, s_ymx_q;

  logic [31:0] qx_q, qy_q, qx_d, qy_d;
  logic [21:0] rx_q, ry_q, rx_d, ry_d;
  logic [22:0] tx, ty;
  logic [4:0]  it_q;

  logic        rv_q, fnd_q, ovr_q;
  logic [10:0] cx_q, oxmn_q, oxmx_q;
  logic [9:0]  cy_q, oymn_q, oymx_q;
  logic [21:0] pc_q;

  // Next accumulator values: restart on boundary, then add this pixel.
  always_comb begin
    cnt_d = cnt_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    xmn_d = xmn_q;
    xmx_d = xmx_q;
    ymn_d = ymn_q;
    ymx_d = ymx_q;
    if (bnd) begin
      cnt_d = '0;
      sx_d  = '0;
      sy_d  = '0;
      xmn_d = 11'd2047;
      xmx_d = '0;
      ymn_d = 10'd1023;
      ymx_d = '0;
    end
    if (qual) begin
      cnt_d = cnt_d + 22'd1;
      sx_d  = sx_d + 32'(CamPix_count_in);
      sy_d  = sy_d + 32'(CamHsync_count_in);
      if (CamPix_count_in < xmn_d) xmn_d = CamPix_count_in;
      if (CamPix_count_in > xmx_d) xmx_d = CamPix_count_in;
      if (CamHsync_count_in < ymn_d) ymn_d = CamHsync_count_in;
      if (CamHsync_count_in > ymx_d) ymx_d = CamHsync_count_in;
    end
  end

  // One restoring-divide step for both coordinates.
  always_comb begin
    tx   = {rx_q, qx_q[31]};
    ty   = {ry_q, qy_q[31]};
    qx_d = {qx_q[30:0], 1'b0};
    qy_d = {qy_q[30:0], 1'b0};
    rx_d = tx[21:0];
    ry_d = ty[21:0];
    if (tx >= {1'b0, s_cnt_q}) begin
      rx_d    = 22'(tx - {1'b0, s_cnt_q});
      qx_d[0] = 1'b1;
    end
    if (ty >= {1'b0, s_cnt_q}) begin
      ry_d    = 22'(ty - {1'b0, s_cnt_q});
      qy_d[0] = 1'b1;
    end
  end

  // Control: divide only when the snapshot has enough pixels.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bnd) state_d = (cnt_q >= MIN_P) ? DIV : DONE;
      end
      DIV: begin
        if (it_q == 5'd31) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Accumulators, snapshot, divider and result registers.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      xmn_q   <= 11'd2047;
      xmx_q   <= '0;
      ymn_q   <= 10'd1023;
      ymx_q   <= '0;
      s_cnt_q <= '0;
      s_xmn_q <= '0;
      s_xmx_q <= '0;
      s_ymn_q <= '0;
      s_ymx_q <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      it_q    <= '0;
      rv_q    <= 1'b0;
      fnd_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      oxmn_q  <= '0;
      oxmx_q  <= '0;
      oymn_q  <= '0;
      oymx_q  <= '0;
      pc_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      xmn_q <= xmn_d;
      xmx_q <= xmx_d;
      ymn_q <= ymn_d;
      ymx_q <= ymx_d;
      ovr_q <= bnd && (state_q != IDLE);
      rv_q  <= (state_q == DONE);
      if (state_q == IDLE && bnd) begin
        s_cnt_q <= cnt_q;
        s_xmn_q <= xmn_q;
        s_xmx_q <= xmx_q;
        s_ymn_q <= ymn_q;
        s_ymx_q <= ymx_q;
        qx_q    <= sx_q;
        qy_q    <= sy_q;
        rx_q    <= '0;
        ry_q    <= '0;
        it_q    <= '0;
      end
      if (state_q == DIV) begin
        qx_q <= qx_d;
        qy_q <= qy_d;
        rx_q <= rx_d;
        ry_q <= ry_d;
        it_q <= it_q + 5'd1;
      end
      if (state_q == DONE) begin
        pc_q <= s_cnt_q;
        if (s_cnt_q >= MIN_P) begin
          fnd_q  <= 1'b1;
          cx_q   <= qx_q[10:0];
          cy_q   <= qy_q[9:0];
          oxmn_q <= s_xmn_q;
          oxmx_q <= s_xmx_q;
          oymn_q <= s_ymn_q;
          oymx_q <= s_ymx_q;
        end else begin
          fnd_q  <= 1'b0;
          cx_q   <= '0;
          cy_q   <= '0;
          oxmn_q <= '0;
          oxmx_q <= '0;
          oymn_q <= '0;
          oymx_q <= '0;
        end
      end
    end
  end

  assign result_valid = rv_q;
  assign found        = fnd_q;
  assign centroid_x   = cx_q;
  assign centroid_y   = cy_q;
  assign x_min        = oxmn_q;
  assign x_max        = oxmx_q;
  assign y_min        = oymn_q;
  assign y_max        = oymx_q;
  assign pix_count    = pc_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_object_centroid.sv
// tb_object_centroid: directed checks of object_centroid
// (MIN_PIXELS=16 main instance, MIN_PIXELS=1 corner instance).
module tb_object_centroid;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [9:0]  ly = '0;
  logic [10:0] lx = '0;
  logic [15:0] din = '0;

  logic        rv, fnd, ovr;
  logic [10:0] cx, xmn, xmx;
  logic [9:0]  cy, ymn, ymx;
  logic [21:0] pc;

  logic        rv1, fnd1, ovr1;
  logic [10:0] cx1, xmn1, xmx1;
  logic [9:0]  cy1, ymn1, ymx1;
  logic [21:0] pc1;

  logic [86:0] res, res1;
  assign res  = {rv, fnd, cx, cy, xmn, xmx, ymn, ymx, pc};
  assign res1 = {rv1, fnd1, cx1, cy1, xmn1, xmx1, ymn1, ymx1, pc1};

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  object_centroid #(.MIN_PIXELS(16)) dut (
    .clk(clk), .reset(reset), .Cam_enable_in(en),
    .CamHsync_count_in(ly), .CamPix_count_in(lx), .data_in(din),
    .result_valid(rv), .found(fnd),
    .centroid_x(cx), .centroid_y(cy),
    .x_min(xmn), .x_max(xmx), .y_min(ymn), .y_max(ymx),
    .pix_count(pc), .overrun(ovr)
  );

  object_centroid #(.MIN_PIXELS(1)) dut1 (
    .clk(clk), .reset(reset), .Cam_enable_in(en),
    .CamHsync_count_in(ly), .CamPix_count_in(lx), .data_in(din),
    .result_valid(rv1), .found(fnd1),
    .centroid_x(cx1), .centroid_y(cy1),
    .x_min(xmn1), .x_max(xmx1), .y_min(ymn1), .y_max(ymx1),
    .pix_count(pc1), .overrun(ovr1)
  );

  localparam logic [86:0] EXP16 =
    {1'b1, 1'b1, 11'd101, 10'd51, 11'd100, 11'd103,
     10'd50, 10'd53, 22'd16};

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pix(input logic [10:0] x, input logic [9:0] y,
                     input logic fg);
    en  = 1'b1;
    lx  = x;
    ly  = y;
    din = fg ? 16'hffff : 16'h0000;
    tick();
  endtask

  task automatic bnd(input logic fg);
    pix(11'd0, 10'd0, fg);
    en = 1'b0;
  endtask

  task automatic block(input int n);
    int k;
    k = 0;
    for (int y = 50; y < 54; y++)
      for (int x = 100; x < 104; x++) begin
        if (k < n) pix(11'(x), 10'(y), 1'b1);
        k++;
      end
    en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    vec++;
    if (res !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %h exp 0", res);
    end
    vec++;
    if (ovr !== 1'b0) begin
      errs++;
      $display("FAIL reset_overrun: got %b exp 0", ovr);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_found();
    block(16);
    bnd(1'b0);
    idle(32);
    vec++;
    if (rv !== 1'b0) begin
      errs++;
      $display("FAIL found_e32_valid: got %b exp 0", rv);
    end
    tick();
    vec++;
    if (res !== EXP16) begin
      errs++;
      $display("FAIL found_e33: got %h exp %h", res, EXP16);
    end
    tick();
    vec++;
    if (res !== {1'b0, EXP16[85:0]}) begin
      errs++;
      $display("FAIL found_e34_hold: got %h exp %h",
               res, {1'b0, EXP16[85:0]});
    end
    idle(10);
  endtask

  task automatic test_not_found();
    logic [86:0] e;
    e = {2'b10, 63'd0, 22'd15};
    block(15);
    bnd(1'b0);
    tick();
    vec++;
    if (res !== e) begin
      errs++;
      $display("FAIL notfound_e1: got %h exp %h", res, e);
    end
    tick();
    vec++;
    if (rv !== 1'b0) begin
      errs++;
      $display("FAIL notfound_e2_valid: got %b exp 0", rv);
    end
    idle(40);
  endtask

  task automatic test_corner();
    logic [86:0] e, e1;
    e  = {2'b10, 63'd0, 22'd1};
    e1 = {1'b1, 1'b1, 11'd2047, 10'd1023, 11'd2047, 11'd2047,
          10'd1023, 10'd1023, 22'd1};
    pix(11'd2047, 10'd1023, 1'b1);
    bnd(1'b0);
    tick();
    vec++;
    if (res !== e) begin
      errs++;
      $display("FAIL corner_min16_e1: got %h exp %h", res, e);
    end
    idle(32);
    vec++;
    if (res1 !== e1) begin
      errs++;
      $display("FAIL corner_min1_e33: got %h exp %h", res1, e1);
    end
    idle(5);
  endtask

  task automatic test_back_to_back();
    int pulses;
    block(16);
    bnd(1'b0);
    idle(9);
    vec++;
    if (ovr !== 1'b0) begin
      errs++;
      $display("FAIL b2b_ovr_e9: got %b exp 0", ovr);
    end
    bnd(1'b0);
    vec++;
    if (ovr !== 1'b1) begin
      errs++;
      $display("FAIL b2b_ovr_e10: got %b exp 1", ovr);
    end
    tick();
    vec++;
    if (ovr !== 1'b0) begin
      errs++;
      $display("FAIL b2b_ovr_e11: got %b exp 0", ovr);
    end
    idle(22);
    vec++;
    if (res !== EXP16) begin
      errs++;
      $display("FAIL b2b_e33: got %h exp %h", res, EXP16);
    end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rv) pulses++;
    end
    vec++;
    if (pulses !== 0) begin
      errs++;
      $display("FAIL b2b_extra_result: got %0d exp 0", pulses);
    end
  endtask

  task automatic test_boundary_pixel();
    logic [86:0] e0, e;
    e0 = {2'b10, 63'd0, 22'd0};
    e  = {1'b1, 1'b1, 11'd95, 10'd48, 11'd0, 11'd103,
          10'd0, 10'd53, 22'd17};
    bnd(1'b1);
    tick();
    vec++;
    if (res !== e0) begin
      errs++;
      $display("FAIL bpix_empty_e1: got %h exp %h", res, e0);
    end
    idle(5);
    block(16);
    bnd(1'b0);
    idle(33);
    vec++;
    if (res !== e) begin
      errs++;
      $display("FAIL bpix_e33: got %h exp %h", res, e);
    end
    idle(5);
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    block(16);
    bnd(1'b0);
    idle(15);
    reset = 1'b1;
    #1;
    vec++;
    if (res !== '0) begin
      errs++;
      $display("FAIL middiv_reset_out: got %h exp 0", res);
    end
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rv) pulses++;
    end
    vec++;
    if (pulses !== 0) begin
      errs++;
      $display("FAIL middiv_no_result: got %0d exp 0", pulses);
    end
    block(16);
    bnd(1'b0);
    idle(33);
    vec++;
    if (res !== EXP16) begin
      errs++;
      $display("FAIL middiv_next_frame: got %h exp %h", res, EXP16);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_found();
    test_not_found();
    test_corner();
    test_back_to_back();
    test_boundary_pixel();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/object_centroid.md
# object_centroid

Downstream consumer of the 1x9 median-filtered binary mask in the camera pipeline. Accumulates foreground pixel statistics over each frame:
- pixel count
- coordinate sums
- bounding box

At each frame boundary it snapshots the totals and computes the centroid with an iterative divider. It then presents the centroid, bounding box and count with a one-cycle valid pulse for the Avalon-MM register bank to latch.

## Interface
Parameters:
- MIN_PIXELS, 16: minimum foreground pixel count for a frame to report `found=1`; range 1..2^22-1.

Ports:
- clk  in  1  pipeline clock; all registers update on the falling edge, matching the neighbouring camera stages.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Cam_enable_in  in  1  pixel valid; inputs are ignored when 0.
- CamHsync_count_in  in  10  line index (y) of the current pixel.
- CamPix_count_in  in  11  pixel index (x) within the line.
- data_in  in  16  filtered mask; `data_in[15]=1` marks a foreground pixel (upstream emits 16'hffff / 16'h0000).
- result_valid  out  1  one-cycle pulse; all result outputs are updated in the same cycle.
- found  out  1  previous frame's count was >= MIN_PIXELS.
- centroid_x  out  11  floor(sum_x / count).
- centroid_y  out  10  floor(sum_y / count).
- x_min, x_max  out  11 each  horizontal bounding box.
- y_min, y_max  out  10 each  vertical bounding box.
- pix_count  out  22  foreground pixel count of the previous frame.
- overrun  out  1  one-cycle pulse when a frame boundary arrives while a division is still busy.

## Operation
Accumulators (frame in progress):
- cnt: 22 bits.
- sum_x, sum_y: 32 bits each.
- bbox: xmin/xmax/ymin/ymax.
- Empty state: cnt=0, sums=0, xmin=2047, xmax=0, ymin=1023, ymax=0.

Accumulation:
- Qualifying pixel: `Cam_enable_in=1` and `data_in[15]=1`.
- On each qualifying pixel: cnt+=1; sum_x+=x; sum_y+=y; bbox min/max updated.
- Widths are sized so none can overflow for a 2048x1024 frame. No saturation logic is required.

Frame boundary:
- A boundary is `Cam_enable_in=1` with `CamHsync_count_in=0` and `CamPix_count_in=0`.
- On a boundary edge the accumulators are copied to snapshot registers.
- The accumulators then restart as empty plus the boundary pixel's own contribution, which belongs to the new frame.
- The first boundary after reset is treated identically; its snapshot has cnt=0.

State machine (IDLE, DIV, DONE):
- IDLE + boundary with snapshot cnt >= MIN_PIXELS: go to DIV; load dividers; iteration counter=0.
- IDLE + boundary with snapshot cnt < MIN_PIXELS: go to DONE directly.
- DIV: two parallel 32-step restoring dividers (sum_x/cnt, sum_y/cnt), one quotient bit per edge. After the 32nd iteration, go to DONE.
- DONE: load the outputs; result_valid=1 for exactly one cycle; return to IDLE.
- Boundary while in DIV or DONE: accumulators still restart as normal. The new snapshot is discarded, the running computation is unaffected, and overrun pulses for one cycle.

Results when found=1:
- centroid and bbox come from the divider and snapshot.
- Quotients are truncated to 11 and 10 bits; they are provably in range.

Results when found=0:
- centroid_x, centroid_y, x_min, x_max, y_min and y_max are all 0.
- pix_count still shows the true snapshot count.

Output holding: outputs keep their values between result_valid pulses.

## Timing
- Reset values: all outputs 0 (including found, result_valid, overrun); state IDLE; accumulators empty; snapshot cleared.
- Boundary sampled at edge E0:
  - found case: result_valid is high from E33 to E34. E1..E32 are the divide iterations; outputs load at E33.
  - not-found case: result_valid is high from E1 to E2.
- overrun is asserted on the edge that samples the offending boundary and lasts one cycle.
- Accumulation has no bubbles: a qualifying pixel is counted on every enabled edge, including edges during DIV and DONE.
- Reset asserted mid-DIV: the division aborts, and no result_valid is issued for that frame.

## Test plan
- 4x4 foreground block at x=100..103, y=50..53, MIN_PIXELS=16, then a boundary -> E33:
  - result_valid=1, found=1, pix_count=16
  - centroid_x=101 (1624/16), centroid_y=51 (824/16)
  - bbox x 100..103, y 50..53
- Same frame with one pixel removed (15 pixels) -> at E1: result_valid=1, found=0, pix_count=15, centroid and bbox all 0.
- Single pixel at (2047,1023), MIN_PIXELS=1 -> centroid (2047,1023), bbox min=max=(2047,1023), pix_count=1.
- Two boundaries 10 cycles apart after a qualifying frame -> overrun pulses once. The first frame's result is still correct at E33, and no second result is produced.
- Boundary pixel itself foreground at (0,0) -> counted in the next frame: the next report has pix_count incremented by 1 and x_min=0, y_min=0.
- Reset asserted at E15 of DIV -> all outputs 0 immediately. No result_valid follows, and the next frame reports normally.
